stream_prefetch: RTL and testbench
==================================

Name: stream_prefetch

Overview:
- Parametrised next-N-line stream prefetcher. Sits between the CPU/L1 demand port and the downstream cache/memory port.
- On a demand miss it fetches the demand line, then issues up to PF_DEGREE sequential line prefetches into a small fully-associative prefetch buffer.
- Demand hits in the buffer return in one cycle and trigger a one-line top-up prefetch.

Parameters:
- ADDR_W, 32, address width in bits.
- OFFSET_BITS, 5, log2 of line size in bytes (32 B line).
- LINE_W, 256, line data width in bits.
- BUF_DEPTH, 4, number of prefetch buffer entries (power of 2, ≥2).
- PF_DEGREE, 2, lines prefetched after a demand miss (0..BUF_DEPTH; 0 disables prefetching).
- PAGE_BITS, 12, prefetches never cross a 2^PAGE_BITS byte boundary.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_address  in  ADDR_W  CPU demand byte address
- mem_read  in  1  CPU demand request; held until cpu_resp
- cpu_resp  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  LINE_W  line data, valid while cpu_resp=1
- mem_address_out  out  ADDR_W  downstream line-aligned address (low OFFSET_BITS zero)
- cache_read  out  1  downstream read request; held until cache_resp
- cache_resp  in  1  downstream completion pulse
- cache_rdata  in  LINE_W  downstream data, valid with cache_resp

Behaviour:
- Reset: cpu_resp=0, cpu_rdata=0, cache_read=0, mem_address_out=0. All buffer entries invalid, pf_count=0, state IDLE. Reset mid-transaction abandons it; a later stray cache_resp in IDLE is ignored.
- Outputs are registered.
- States:
  - IDLE: no downstream transaction.
  - DEMAND: cache_read=1, address = line(mem_address).
  - PREFETCH: cache_read=1, address = pf_addr.
- IDLE with mem_read=1 and cpu_resp=0:
  - Buffer hit (tag = address[ADDR_W-1:OFFSET_BITS]): cpu_resp=1 and cpu_rdata=entry data in the next cycle, entry invalidated. If pf_addr is valid and in-page, pf_count increments by 1 (saturating at BUF_DEPTH).
  - Miss: flush the buffer, enter DEMAND; cache_read rises in the next cycle.
- DEMAND, on cache_resp:
  - Cycle after: cpu_resp=1, cpu_rdata=cache_rdata, cache_read=0.
  - Set pf_addr = line+1 (line-granular add, mod 2^ADDR_W) and pf_count = PF_DEGREE.
  - Next state IDLE.
- IDLE with no serviceable demand, pf_count>0 and pf_addr in the same page as its predecessor line: enter PREFETCH. Otherwise pf_count=0.
- PREFETCH, on cache_resp:
  - Write the line into an invalid entry; if none is invalid, overwrite the round-robin victim pointer entry, then advance the pointer.
  - pf_addr += 1 line, pf_count -= 1, return to IDLE (re-evaluates demand first).
- Demand arriving during PREFETCH: the downstream request is never aborted.
  - If line(mem_address) == in-flight pf_addr: cache_rdata is forwarded to cpu_resp/cpu_rdata in the cycle after cache_resp and is not stored; pf_count decrements as normal.
  - Otherwise the demand waits, and is resolved as hit/miss in IDLE after the prefetch completes.
- Priority in IDLE: demand > prefetch.
- cpu_resp is never high for two consecutive cycles. A mem_read sampled while cpu_resp=1 is not accepted.
- Wrap-around: address increment wraps mod 2^ADDR_W. The page check stops prefetch at 0x...FE0 → 0x...000.
- cache_resp outside DEMAND/PREFETCH is ignored.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined:
  - Adds outputs pf_issued (32-bit): counts prefetch transactions that complete, i.e. cache_resp in PREFETCH.
  - Adds pf_useful (32-bit): counts buffer hits plus in-flight forwards.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- When undefined: the ports and counters are absent. Core timing is identical either way.

Decomposition:
- Package prefetch_pkg holds:
  - state enum {IDLE, DEMAND, PREFETCH}.
  - pf_entry_t struct {valid, tag, data}.
  - Constant helper functions line_of() and same_page().
- Sub-module prefetch_buffer: BUF_DEPTH entries with a combinational lookup port (hit, idx, data), write port, invalidate-by-idx, flush, and round-robin victim pointer.
- The FSM and address logic stay in stream_prefetch.

Test Plan:
- Demand miss: reset, read 0xABCD1234 → next cycle cache_read=1, mem_address_out=0xABCD1220. After cache_resp, cpu_resp for one cycle with data. Then prefetches to 0xABCD1240 and 0xABCD1260, then cache_read=0.
- Buffer hit: after test 1, read 0xABCD1244 → cpu_resp next cycle with the 0xABCD1240 line and no demand cache_read. Top-up prefetch to 0xABCD1280 is issued.
- In-flight forward: read 0x00000100 with a 10-cycle downstream latency. During the prefetch of 0x120, read 0x00000128 → cpu_resp the cycle after that cache_resp; the line is not in the buffer.
- Unrelated demand during prefetch: read 0x5000 while 0x120 is in flight → prefetch completes, buffer flushed, DEMAND to 0x5000, then prefetches 0x5020/0x5040.
- Page boundary: read 0x00000FE4, PF_DEGREE=2 → demand 0x00000FE0 only; no downstream request to 0x00001000.
- Reset mid-PREFETCH: assert rst for 1 cycle → all outputs 0, then a cache_resp pulse is ignored. Read 0xABCD1244 misses (buffer flushed).

Source files
------------

// File: rtl/prefetch_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_pkg
// Shared types and helpers for the stream prefetcher.
//   - state_t     : controller states (IDLE / DEMAND / PREFETCH)
//   - pf_entry_t  : one prefetch-buffer entry {valid, tag, data}
//   - line_of()   : clears the byte-offset bits of an address
//   - same_page() : true when two addresses share the same page
// The entry struct is sized from the DEF_* constants, which are also the
// default parameter values of stream_prefetch.
// -----------------------------------------------------------------------------
package prefetch_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_OFFSET_BITS = 5;
    localparam int DEF_LINE_W      = 256;
    localparam int DEF_BUF_DEPTH   = 4;
    localparam int DEF_PF_DEGREE   = 2;
    localparam int DEF_PAGE_BITS   = 12;
    localparam int PF_TAG_W        = DEF_ADDR_W - DEF_OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEMAND   = 2'd1,
        PREFETCH = 2'd2
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [PF_TAG_W-1:0]   tag;
        logic [DEF_LINE_W-1:0] data;
    } pf_entry_t;

    // Helpers work on a 64-bit container so any ADDR_W up to 64 can use them.
    function automatic logic [63:0] line_of(input logic [63:0] addr, input int offset_bits);
        return addr & ~((64'd1 << offset_bits) - 64'd1);
    endfunction

    function automatic logic same_page(input logic [63:0] a, input logic [63:0] b,
                                       input int page_bits);
        return (a >> page_bits) == (b >> page_bits);
    endfunction

endpackage

// File: rtl/prefetch_buffer.sv
// -----------------------------------------------------------------------------
// prefetch_buffer
// Small fully-associative store of prefetched lines.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   lookup_tag            tag to search (combinational)
//   lookup_hit/idx/data   search result
//   wr_en/wr_tag/wr_data  insert a line: first invalid entry, else the
//                         round-robin victim (pointer advances on replacement)
//   inv_en/inv_idx        invalidate one entry
//   flush                 invalidate all entries
// -----------------------------------------------------------------------------
module prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int DEPTH = DEF_BUF_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PF_TAG_W-1:0]   lookup_tag,
    output logic                  lookup_hit,
    output logic [IDX_W-1:0]      lookup_idx,
    output logic [DEF_LINE_W-1:0] lookup_data,
    input  logic                  wr_en,
    input  logic [PF_TAG_W-1:0]   wr_tag,
    input  logic [DEF_LINE_W-1:0] wr_data,
    input  logic                  inv_en,
    input  logic [IDX_W-1:0]      inv_idx,
    input  logic                  flush
);

    pf_entry_t         entry_q [DEPTH];
    logic [DEPTH-1:0]  match;
    logic              has_free;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  victim_q, victim_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = entry_q[gi].valid && (entry_q[gi].tag == lookup_tag);
        end
    endgenerate

    // Lowest-index match / lowest-index free slot.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_idx = '0;
        has_free   = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                lookup_hit = 1'b1;
                lookup_idx = IDX_W'(i);
            end
            if (!entry_q[i].valid) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign lookup_data = entry_q[lookup_idx].data;
    assign wr_idx      = has_free ? free_idx : victim_q;

    always_comb begin
        victim_d = victim_q;
        if (wr_en && !has_free) begin
            victim_d = victim_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            victim_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else begin
            victim_q <= victim_d;
            if (wr_en) begin
                entry_q[wr_idx] <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
            end
            if (inv_en) begin
                entry_q[inv_idx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_prefetch.sv
// -----------------------------------------------------------------------------
// stream_prefetch
// Next-N-line stream prefetcher between a CPU demand port and a downstream
// cache/memory port. A demand miss fetches its line, then up to PF_DEGREE
// following lines (never crossing a 2^PAGE_BITS page) are prefetched into
// prefetch_buffer. Buffer hits answer in one cycle and request one more line.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mem_address, mem_read             CPU demand (held until cpu_resp)
//   cpu_resp, cpu_rdata               one-cycle completion pulse + line data
//   mem_address_out, cache_read       downstream line request (held until resp)
//   cache_resp, cache_rdata           downstream completion pulse + data
//   pf_issued, pf_useful              statistics, only with PREFETCH_STATS_EN
// Optional feature macro: PREFETCH_STATS_EN.
// -----------------------------------------------------------------------------
module stream_prefetch
    import prefetch_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS,
    parameter int LINE_W      = DEF_LINE_W,
    parameter int BUF_DEPTH   = DEF_BUF_DEPTH,
    parameter int PF_DEGREE   = DEF_PF_DEGREE,
    parameter int PAGE_BITS   = DEF_PAGE_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_read,
    output logic              cpu_resp,
    output logic [LINE_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_address_out,
    output logic              cache_read,
    input  logic              cache_resp,
    input  logic [LINE_W-1:0] cache_rdata
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]       pf_issued,
    output logic [31:0]       pf_useful
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(1) << OFFSET_BITS;

    state_t            state_q, state_d;
    logic              cpu_resp_q, cpu_resp_d;
    logic [LINE_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cache_read_q, cache_read_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic              pf_valid_q, pf_valid_d;
    logic [CNT_W-1:0]  pf_count_q, pf_count_d;

    logic [ADDR_W-1:0]     req_line;
    logic                  demand_ok;
    logic                  fwd_match;
    logic                  pf_in_page;
    logic                  buf_hit, buf_wr, buf_inv, buf_flush;
    logic [IDX_W-1:0]      buf_idx;
    logic [DEF_LINE_W-1:0] buf_data;

    assign req_line  = ADDR_W'(line_of(64'(mem_address), OFFSET_BITS));
    // A demand seen while cpu_resp is high belongs to the request just answered.
    assign demand_ok = mem_read && !cpu_resp_q;
    assign fwd_match = demand_ok && (req_line == pf_addr_q);
    // pf_addr is in-page when it shares a page with the line before it.
    assign pf_in_page = pf_valid_q &&
        same_page(64'(pf_addr_q), 64'(pf_addr_q - LINE_INC), PAGE_BITS);

    prefetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .lookup_tag  (PF_TAG_W'(mem_address[ADDR_W-1:OFFSET_BITS])),
        .lookup_hit  (buf_hit),
        .lookup_idx  (buf_idx),
        .lookup_data (buf_data),
        .wr_en       (buf_wr),
        .wr_tag      (PF_TAG_W'(pf_addr_q[ADDR_W-1:OFFSET_BITS])),
        .wr_data     (DEF_LINE_W'(cache_rdata)),
        .inv_en      (buf_inv),
        .inv_idx     (buf_idx),
        .flush       (buf_flush)
    );

    always_comb begin
        state_d      = state_q;
        cpu_resp_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        cache_read_d = cache_read_q;
        addr_out_d   = addr_out_q;
        pf_addr_d    = pf_addr_q;
        pf_valid_d   = pf_valid_q;
        pf_count_d   = pf_count_q;
        buf_wr       = 1'b0;
        buf_inv      = 1'b0;
        buf_flush    = 1'b0;
        case (state_q)
            IDLE: begin
                if (demand_ok) begin
                    if (buf_hit) begin
                        cpu_resp_d  = 1'b1;
                        cpu_rdata_d = LINE_W'(buf_data);
                        buf_inv     = 1'b1;
                        if (pf_in_page && (pf_count_q < CNT_W'(BUF_DEPTH))) begin
                            pf_count_d = pf_count_q + CNT_W'(1);
                        end
                    end else begin
                        buf_flush    = 1'b1;
                        state_d      = DEMAND;
                        cache_read_d = 1'b1;
                        addr_out_d   = req_line;
                    end
                end else if ((pf_count_q != '0) && pf_in_page) begin
                    state_d      = PREFETCH;
                    cache_read_d = 1'b1;
                    addr_out_d   = pf_addr_q;
                end else begin
                    pf_count_d = '0;
                end
            end
            DEMAND: begin
                if (cache_resp) begin
                    cpu_resp_d   = 1'b1;
                    cpu_rdata_d  = cache_rdata;
                    cache_read_d = 1'b0;
                    pf_addr_d    = addr_out_q + LINE_INC;
                    pf_valid_d   = 1'b1;
                    pf_count_d   = CNT_W'(PF_DEGREE);
                    state_d      = IDLE;
                end
            end
            PREFETCH: begin
                if (cache_resp) begin
                    // The waiting demand wants exactly this line: hand it over
                    // instead of storing it.
                    if (fwd_match) begin
                        cpu_resp_d  = 1'b1;
                        cpu_rdata_d = cache_rdata;
                    end else begin
                        buf_wr = 1'b1;
                    end
                    cache_read_d = 1'b0;
                    pf_addr_d    = pf_addr_q + LINE_INC;
                    pf_count_d   = pf_count_q - CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cpu_resp_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            cache_read_q <= 1'b0;
            addr_out_q   <= '0;
            pf_addr_q    <= '0;
            pf_valid_q   <= 1'b0;
            pf_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cpu_resp_q   <= cpu_resp_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cache_read_q <= cache_read_d;
            addr_out_q   <= addr_out_d;
            pf_addr_q    <= pf_addr_d;
            pf_valid_q   <= pf_valid_d;
            pf_count_q   <= pf_count_d;
        end
    end

    assign cpu_resp        = cpu_resp_q;
    assign cpu_rdata       = cpu_rdata_q;
    assign cache_read      = cache_read_q;
    assign mem_address_out = addr_out_q;

`ifdef PREFETCH_STATS_EN
    logic [31:0] pf_issued_q, pf_issued_d;
    logic [31:0] pf_useful_q, pf_useful_d;
    logic        pf_done_evt, pf_useful_evt;

    assign pf_done_evt   = (state_q == PREFETCH) && cache_resp;
    assign pf_useful_evt = buf_inv || (pf_done_evt && fwd_match);

    always_comb begin
        pf_issued_d = pf_issued_q;
        pf_useful_d = pf_useful_q;
        if (pf_done_evt && (pf_issued_q != 32'hFFFF_FFFF)) begin
            pf_issued_d = pf_issued_q + 32'd1;
        end
        if (pf_useful_evt && (pf_useful_q != 32'hFFFF_FFFF)) begin
            pf_useful_d = pf_useful_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pf_issued_q <= '0;
            pf_useful_q <= '0;
        end else begin
            pf_issued_q <= pf_issued_d;
            pf_useful_q <= pf_useful_d;
        end
    end

    assign pf_issued = pf_issued_q;
    assign pf_useful = pf_useful_q;
`endif

endmodule

// File: tb/tb_stream_prefetch.sv
// -----------------------------------------------------------------------------
// tb_stream_prefetch
// Directed scoreboard bench for stream_prefetch. Stimulus pushes the expected
// downstream request addresses and CPU response data into queues; a monitor
// pops and compares whenever a new cache_read request or a cpu_resp appears.
// A responder process models the downstream port with a programmable latency.
// -----------------------------------------------------------------------------
module tb_stream_prefetch;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         cpu_resp;
    logic [255:0] cpu_rdata;
    logic [31:0]  mem_address_out;
    logic         cache_read;
    logic         cache_resp;
    logic [255:0] cache_rdata;
`ifdef PREFETCH_STATS_EN
    logic [31:0]  pf_issued;
    logic [31:0]  pf_useful;
`endif

    stream_prefetch dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .cpu_resp        (cpu_resp),
        .cpu_rdata       (cpu_rdata),
        .mem_address_out (mem_address_out),
        .cache_read      (cache_read),
        .cache_resp      (cache_resp),
        .cache_rdata     (cache_rdata)
`ifdef PREFETCH_STATS_EN
        ,
        .pf_issued       (pf_issued),
        .pf_useful       (pf_useful)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  exp_req [$];
    logic [255:0] exp_cpu [$];

    int latency = 2;
    bit resp_en = 1'b1;
    bit stray   = 1'b0;

    function automatic logic [255:0] line_data(input logic [31:0] a);
        return {8{a ^ 32'hC3A5_0F1E}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Downstream responder: answers a held cache_read after 'latency' cycles.
    initial begin : responder
        int lat_cnt;
        lat_cnt     = 0;
        cache_resp  = 1'b0;
        cache_rdata = '0;
        forever begin
            @(negedge clk);
            cache_resp = 1'b0;
            if (stray) begin
                stray       = 1'b0;
                cache_resp  = 1'b1;
                cache_rdata = line_data(32'hDEAD_0000);
            end else if (resp_en && cache_read && !rst) begin
                if (lat_cnt >= latency) begin
                    cache_resp  = 1'b1;
                    cache_rdata = line_data(mem_address_out);
                    lat_cnt     = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: compares every new downstream request and every CPU response.
    initial begin : monitor
        bit cr_prev;
        bit resp_prev;
        cr_prev   = 1'b0;
        resp_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cpu_resp) begin
                    check("cpu_resp_not_back_to_back", resp_prev, 1'b0);
                    if (exp_cpu.size() == 0) begin
                        check("unexpected_cpu_resp", cpu_rdata, '0);
                        if (cpu_rdata === '0) begin
                            failures++;
                            $display("FAIL unexpected_cpu_resp: got resp expected none");
                        end
                    end else begin
                        check("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
                    end
                end
                if (cache_read && !cr_prev) begin
                    if (exp_req.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_request: got %0h expected none", mem_address_out);
                    end else begin
                        check("req_addr", mem_address_out, exp_req.pop_front());
                    end
                end
            end
            cr_prev   = cache_read;
            resp_prev = cpu_resp;
        end
    end

    task automatic start_read(input logic [31:0] a);
        mem_address = a;
        mem_read    = 1'b1;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cpu_resp && cyc < 400);
        check("resp_arrived", cpu_resp, 1'b1);
        mem_read = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || cache_read) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("quiet_reached", (n < 500), 1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_inflight(input logic [31:0] a);
        int n;
        n = 0;
        while (!(cache_read && mem_address_out == a) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("inflight_seen", (n < 500), 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cyc;
        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_resp",   cpu_resp, 1'b0);
        check("rst_cpu_rdata",  cpu_rdata, '0);
        check("rst_cache_read", cache_read, 1'b0);
        check("rst_addr_out",   mem_address_out, '0);
        rst = 1'b0;
        @(negedge clk);

        // Demand miss, then two sequential prefetches.
        exp_req.push_back(32'hABCD_1220);
        exp_req.push_back(32'hABCD_1240);
        exp_req.push_back(32'hABCD_1260);
        exp_cpu.push_back(line_data(32'hABCD_1220));
        start_read(32'hABCD_1234);
        @(negedge clk);
        check("miss_cache_read_next", cache_read, 1'b1);
        check("miss_addr_next", mem_address_out, 32'hABCD_1220);
        wait_resp(cyc);
        wait_quiet();

        // Buffer hit: one-cycle answer plus a top-up prefetch.
        exp_cpu.push_back(line_data(32'hABCD_1240));
        exp_req.push_back(32'hABCD_1280);
        start_read(32'hABCD_1244);
        wait_resp(cyc);
        check("hit_latency", cyc, 1);
        wait_quiet();

        // In-flight forward with a slow downstream.
        latency = 10;
        exp_req.push_back(32'h0000_0100);
        exp_req.push_back(32'h0000_0120);
        exp_req.push_back(32'h0000_0140);
        exp_cpu.push_back(line_data(32'h0000_0100));
        exp_cpu.push_back(line_data(32'h0000_0120));
        start_read(32'h0000_0100);
        wait_resp(cyc);
        wait_inflight(32'h0000_0120);
        start_read(32'h0000_0128);
        wait_resp(cyc);
        wait_quiet();
        // Forwarded line was not stored: reading it again must miss.
        exp_req.push_back(32'h0000_0120);
        exp_req.push_back(32'h0000_0140);
        exp_req.push_back(32'h0000_0160);
        exp_cpu.push_back(line_data(32'h0000_0120));
        start_read(32'h0000_0128);
        wait_resp(cyc);
        check("fwd_not_stored_miss", (cyc > 1), 1'b1);
        wait_quiet();

        // Unrelated demand while a prefetch is in flight.
        exp_req.push_back(32'h0000_0100);
        exp_req.push_back(32'h0000_0120);
        exp_req.push_back(32'h0000_5000);
        exp_req.push_back(32'h0000_5020);
        exp_req.push_back(32'h0000_5040);
        exp_cpu.push_back(line_data(32'h0000_0100));
        exp_cpu.push_back(line_data(32'h0000_5000));
        start_read(32'h0000_0104);
        wait_resp(cyc);
        wait_inflight(32'h0000_0120);
        start_read(32'h0000_5000);
        wait_resp(cyc);
        wait_quiet();
        latency = 2;
        exp_cpu.push_back(line_data(32'h0000_5020));
        exp_req.push_back(32'h0000_5060);
        start_read(32'h0000_5024);
        wait_resp(cyc);
        check("hit_after_unrelated", cyc, 1);
        wait_quiet();
        // 0x120 was prefetched and then flushed by the 0x5000 miss.
        exp_req.push_back(32'h0000_0120);
        exp_req.push_back(32'h0000_0140);
        exp_req.push_back(32'h0000_0160);
        exp_cpu.push_back(line_data(32'h0000_0120));
        start_read(32'h0000_0124);
        wait_resp(cyc);
        check("flushed_line_miss", (cyc > 1), 1'b1);
        wait_quiet();

        // Page boundary: no prefetch into the next page.
        exp_req.push_back(32'h0000_0FE0);
        exp_cpu.push_back(line_data(32'h0000_0FE0));
        start_read(32'h0000_0FE4);
        wait_resp(cyc);
        wait_quiet();

        // Reset in the middle of a prefetch, then a stray response.
        latency = 10;
        exp_req.push_back(32'hABCD_1220);
        exp_req.push_back(32'hABCD_1240);
        exp_cpu.push_back(line_data(32'hABCD_1220));
        start_read(32'hABCD_1234);
        wait_resp(cyc);
        wait_inflight(32'hABCD_1240);
        resp_en = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_cpu_resp",   cpu_resp, 1'b0);
        check("mid_rst_cpu_rdata",  cpu_rdata, '0);
        check("mid_rst_cache_read", cache_read, 1'b0);
        check("mid_rst_addr_out",   mem_address_out, '0);
        stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stray_no_cpu_resp", cpu_resp, 1'b0);
            check("stray_no_cache_read", cache_read, 1'b0);
        end
        resp_en = 1'b1;
        latency = 2;
        exp_req.push_back(32'hABCD_1240);
        exp_req.push_back(32'hABCD_1260);
        exp_req.push_back(32'hABCD_1280);
        exp_cpu.push_back(line_data(32'hABCD_1240));
        start_read(32'hABCD_1244);
        wait_resp(cyc);
        check("post_rst_miss", (cyc > 1), 1'b1);
        wait_quiet();

        check("exp_req_drained", exp_req.size(), 0);
        check("exp_cpu_drained", exp_cpu.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
